// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, GF(2^8) arithmetic, S-boxes, key step and state packing
package aes_pkg;
    typedef logic [0:3][0:3][7:0] state_t;
    typedef enum logic [2:0] {s_idle, s_expand, s_addkey, s_round, s_done} fsm_t;
    localparam logic [1:10][7:0] rcon = 80'h01_02_04_08_10_20_40_80_1b_36;
    function automatic logic [7:0] xtime(logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction
    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xtime(x);
        end
        return p;
    endfunction
    // multiplicative inverse as a^254; maps 0 to 0 as the S-box requires
    function automatic logic [7:0] gf_inv(logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        logic [7:0] e;
        r = 8'h01;
        p = a;
        e = 8'hfe;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gmul(r, p);
            p = gmul(p, p);
        end
        return r;
    endfunction
    function automatic logic [7:0] rotl(logic [7:0] b, int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction
    function automatic logic [7:0] sbox(logic [7:0] a);
        logic [7:0] v;
        v = gf_inv(a);
        return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
    endfunction
    function automatic logic [7:0] inv_sbox(logic [7:0] a);
        return gf_inv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
    endfunction
    // byte n of the 128-bit word is s[n%4][n/4] (column-major)
    function automatic state_t to_state(logic [127:0] b);
        state_t s;
        for (int n = 0; n < 16; n++) s[n % 4][n / 4] = b[127 - 8 * n -: 8];
        return s;
    endfunction
    function automatic logic [127:0] from_state(state_t s);
        logic [127:0] b;
        for (int n = 0; n < 16; n++) b[127 - 8 * n -: 8] = s[n % 4][n / 4];
        return b;
    endfunction
    function automatic logic [127:0] next_key(logic [127:0] key, logic [7:0] rc);
        logic [31:0] t;
        logic [31:0] n0;
        logic [31:0] n1;
        logic [31:0] n2;
        logic [31:0] n3;
        t  = {sbox(key[23:16]) ^ rc, sbox(key[15:8]), sbox(key[7:0]), sbox(key[31:24])};
        n0 = key[127:96] ^ t;
        n1 = key[95:64] ^ n0;
        n2 = key[63:32] ^ n1;
        n3 = key[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction
endpackage

// File: rtl/aes_decrypt_iter_if.sv
// aes_decrypt_iter_if: input/output handshakes of the iterative AES decrypter
//   in_valid/in_ready/cipher/in_key/key_keep : block intake
//   out_valid/out_ready/plain                : plaintext delivery
//   busy                                     : core not idle
interface aes_decrypt_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] cipher;
    logic [127:0] in_key;
    logic         key_keep;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] plain;
    logic         busy;
    modport master (output in_valid, cipher, in_key, key_keep, out_ready,
                    input in_ready, out_valid, plain, busy);
    modport slave (input in_valid, cipher, in_key, key_keep, out_ready,
                   output in_ready, out_valid, plain, busy);
endinterface

// File: rtl/aes_inv_round.sv
// aes_inv_round: combinational inverse round; st, rk in, last skips InvMixColumns, nxt_st out
module aes_inv_round
    import aes_pkg::*;
(
    input  state_t       st,
    input  logic [127:0] rk,
    input  logic         last,
    output state_t       nxt_st
);
    state_t key_st;
    state_t sub;
    always_comb begin
        key_st = to_state(rk);
        sub = '0;
        nxt_st = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                sub[r][c] = inv_sbox(st[r][(c + 4 - r) % 4]) ^ key_st[r][c];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                nxt_st[r][c] = last ? sub[r][c] :
                    gmul(sub[r][c], 8'd14) ^ gmul(sub[(r + 1) % 4][c], 8'd11) ^
                    gmul(sub[(r + 2) % 4][c], 8'd13) ^ gmul(sub[(r + 3) % 4][c], 8'd9);
    end
endmodule

// File: rtl/aes_decrypt_iter.sv
// aes_decrypt_iter: iterative AES-128 decrypter, one inverse round per clock
//   clk, rst : clock and synchronous active-high reset
//   bus      : aes_decrypt_iter_if.slave (intake, delivery, busy)
//   AES_DEC_KEY_CACHE_EN : reuse the stored key schedule when key_keep is set
module aes_decrypt_iter
    import aes_pkg::*;
(
    input logic              clk,
    input logic              rst,
    aes_decrypt_iter_if.slave bus
);
    fsm_t         fsm;
    fsm_t         nxt;
    state_t       st;
    state_t       round_out;
    logic [127:0] rk [0:10];
    logic [127:0] plain_q;
    logic [3:0]   k;
    logic [3:0]   r;
    logic         accept;
    logic         hit;
    assign accept = bus.in_valid && fsm == s_idle;
`ifdef AES_DEC_KEY_CACHE_EN
    logic cache_ok;
    assign hit = bus.key_keep && cache_ok;
    always_ff @(posedge clk)
        cache_ok <= rst ? 1'b0 : (fsm == s_expand && k == 4'd10) ? 1'b1 : cache_ok;
`else
    logic unused_key_keep;
    assign hit = 1'b0;
    assign unused_key_keep = bus.key_keep;
`endif
    always_ff @(posedge clk) fsm <= rst ? s_idle : nxt;
    always_comb begin
        nxt = fsm;
        case (fsm)
            s_idle:   if (accept) nxt = hit ? s_addkey : s_expand;
            s_expand: if (k == 4'd10) nxt = s_addkey;
            s_addkey: nxt = s_round;
            s_round:  if (r == 4'd0) nxt = s_done;
            s_done:   if (bus.out_ready) nxt = s_idle;
            default:  nxt = s_idle;
        endcase
    end
    assign bus.in_ready  = fsm == s_idle;
    assign bus.out_valid = fsm == s_done;
    assign bus.busy      = fsm != s_idle;
    assign bus.plain     = plain_q;
    aes_inv_round u_round (.st(st), .rk(rk[r]), .last(r == 4'd0), .nxt_st(round_out));
    always_ff @(posedge clk) begin
        if (rst) begin
            st <= '0;
            plain_q <= '0;
            k <= '0;
            r <= '0;
            for (int i = 0; i <= 10; i++) rk[i] <= '0;
        end else begin
            case (fsm)
                s_idle: if (accept) begin
                    st <= to_state(bus.cipher);
                    k <= 4'd1;
                    if (!hit) rk[0] <= bus.in_key;
                end
                s_expand: begin
                    rk[k] <= next_key(rk[k - 4'd1], rcon[k]);
                    k <= k == 4'd10 ? k : k + 4'd1;
                end
                s_addkey: begin
                    st <= st ^ to_state(rk[10]);
                    r <= 4'd9;
                end
                s_round: begin
                    st <= round_out;
                    r <= r == 4'd0 ? r : r - 4'd1;
                    if (r == 4'd0) plain_q <= from_state(round_out);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_decrypt_iter.sv
// tb_aes_decrypt_iter: directed FIPS-197 and random checks against a table-driven InvCipher model
module tb_aes_decrypt_iter;
    logic clk = 1'b0;
    logic rst;
    int vectors = 0;
    int miscompares = 0;
    logic [7:0] sb [256];
    logic [7:0] isb [256];
    localparam logic [127:0] c1_key = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c1_ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] c1_pt  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] b_key  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] b_ct   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] b_pt   = 128'h3243f6a8885a308d313198a2e0370734;
    always #5 clk = ~clk;
    aes_decrypt_iter_if bus ();
    aes_decrypt_iter dut (.clk(clk), .rst(rst), .bus(bus));
    task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    function automatic logic [7:0] gm(logic [7:0] a, logic [7:0] b);
        logic [7:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction
    task automatic build_tables();
        logic [7:0] v;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            v = '0;
            for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) v = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = v[i] ^ v[(i + 4) % 8] ^ v[(i + 5) % 8] ^ v[(i + 6) % 8] ^ v[(i + 7) % 8] ^ c[i];
            sb[x] = s;
            isb[s] = 8'(x);
        end
    endtask
    function automatic logic [127:0] dec_model(logic [127:0] ct, logic [127:0] key);
        logic [7:0] w [176];
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] tmp [4];
        logic [7:0] a [4];
        logic [7:0] rc;
        logic [7:0] b0;
        logic [127:0] res;
        rc = 8'h01;
        for (int n = 0; n < 16; n++) begin
            w[n] = key[127 - 8 * n -: 8];
            s[n] = ct[127 - 8 * n -: 8];
        end
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[i - 4 + j];
            if (i % 16 == 0) begin
                b0 = tmp[0];
                tmp[0] = sb[tmp[1]] ^ rc;
                tmp[1] = sb[tmp[2]];
                tmp[2] = sb[tmp[3]];
                tmp[3] = sb[b0];
                rc = gm(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[i + j] = w[i - 16 + j] ^ tmp[j];
        end
        for (int n = 0; n < 16; n++) s[n] ^= w[160 + n];
        for (int rd = 9; rd >= 0; rd--) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) t[r + 4 * c] = isb[s[r + 4 * ((c - r + 4) % 4)]];
            for (int n = 0; n < 16; n++) t[n] ^= w[16 * rd + n];
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) a[r] = t[4 * c + r];
                for (int r = 0; r < 4; r++)
                    s[4 * c + r] = rd == 0 ? a[r] :
                        gm(a[r], 8'd14) ^ gm(a[(r + 1) % 4], 8'd11) ^
                        gm(a[(r + 2) % 4], 8'd13) ^ gm(a[(r + 3) % 4], 8'd9);
            end
        end
        for (int n = 0; n < 16; n++) res[127 - 8 * n -: 8] = s[n];
        return res;
    endfunction
    task automatic start(logic [127:0] ct, logic [127:0] key, logic keep);
        int n = 0;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        bus.in_valid = 1'b1;
        bus.cipher = ct;
        bus.in_key = key;
        bus.key_keep = keep;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.key_keep = 1'b0;
    endtask
    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask
    task automatic run_block(string tag, logic [127:0] ct, logic [127:0] key, logic keep,
                             logic [127:0] exp_pt, int exp_lat);
        int lat;
        start(ct, key, keep);
        check({tag, "_busy"}, 128'(bus.busy), 128'(1));
        wait_done(lat);
        check({tag, "_lat"}, 128'(lat), 128'(exp_lat));
        check({tag, "_plain"}, bus.plain, exp_pt);
        @(posedge clk); #1;
        check({tag, "_idle"}, 128'(bus.in_ready), 128'(1));
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
    initial begin
        int lat;
        logic [127:0] rk;
        logic [127:0] rc;
        build_tables();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.cipher = '0;
        bus.in_key = '0;
        bus.key_keep = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 128'(bus.in_ready), 128'(1));
        check("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("rst_busy", 128'(bus.busy), 128'(0));
        check("rst_plain", bus.plain, 128'(0));
        rst = 1'b0;
        run_block("c1", c1_ct, c1_key, 1'b0, c1_pt, 21);
        run_block("appb", b_ct, b_key, 1'b0, b_pt, 21);
        bus.out_ready = 1'b0;
        start(c1_ct, c1_key, 1'b0);
        wait_done(lat);
        check("bp_lat", 128'(lat), 128'(21));
        bus.in_valid = 1'b1;
        bus.cipher = b_ct;
        bus.in_key = b_key;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            check("bp_valid", 128'(bus.out_valid), 128'(1));
            check("bp_plain", bus.plain, c1_pt);
            check("bp_in_ready", 128'(bus.in_ready), 128'(0));
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_rel_valid", 128'(bus.out_valid), 128'(0));
        check("bp_rel_ready", 128'(bus.in_ready), 128'(1));
        check("bp_rel_plain", bus.plain, c1_pt);
        start(c1_ct, c1_key, 1'b0);
        repeat (15) @(posedge clk);
        #1;
        check("mid_busy", 128'(bus.busy), 128'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_out_valid", 128'(bus.out_valid), 128'(0));
        check("mid_plain", bus.plain, 128'(0));
        check("mid_in_ready", 128'(bus.in_ready), 128'(1));
        run_block("post_rst", c1_ct, c1_key, 1'b0, c1_pt, 21);
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.cipher = b_ct;
        bus.in_key = b_key;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        check("rst_win_ready", 128'(bus.in_ready), 128'(1));
        check("rst_win_busy", 128'(bus.busy), 128'(0));
        run_block("cache_a", c1_ct, c1_key, 1'b0, c1_pt, 21);
`ifdef AES_DEC_KEY_CACHE_EN
        run_block("cache_b", c1_ct, 128'(0), 1'b1, c1_pt, 11);
`else
        run_block("cache_b", c1_ct, 128'(0), 1'b1, dec_model(c1_ct, 128'(0)), 21);
`endif
        for (int i = 0; i < 6; i++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            rc = {$urandom, $urandom, $urandom, $urandom};
            run_block("rand", rc, rk, 1'b0, dec_model(rc, rk), 21);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
